// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : pipe_hazard_ctrl
// Description: Load-use stall, branch flush, memory-wait and forwarding control
//              for a 5-stage pipeline, with saturating stall/flush statistics.
// Revision   : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL  = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             mem_branch,
    input  logic             mem_jump,
    input  logic             mem_zero,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pc_sel,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    localparam int                WAIT_W       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [3:0]        c_STALL_INIT = 4'(LOAD_STALL - 1);
    localparam logic [WAIT_W-1:0] c_TIMEOUT    = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LD_STALL = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_stall_left, w_stall_nxt;
    logic [WAIT_W-1:0] r_wait, w_wait_nxt, w_wait_inc;
    logic              r_mem_err, w_err_set;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
    logic              w_taken, w_busy, w_load_use;
    logic [3:0]        w_en;     // {pc, ifid, idex, exmem}
    logic [2:0]        w_flush;  // {ifid, idex, exmem}
    logic              w_pc_sel;
    logic [1:0]        w_fwd_a, w_fwd_b;

    assign w_taken    = mem_jump | (mem_branch & mem_zero);
    assign w_busy     = dmem_req & ~dmem_ack;
    assign w_load_use = ex_memtoreg & ex_regwrite & (ex_rd != 5'd0) &
                        ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2)));
    assign w_wait_inc = r_wait + WAIT_W'(1);

    always_comb begin
        w_en        = 4'b1111;
        w_flush     = 3'b000;
        w_pc_sel    = 1'b0;
        w_state_nxt = r_state;
        w_stall_nxt = r_stall_left;
        w_wait_nxt  = r_wait;
        w_err_set   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_busy) begin
                    w_en        = 4'b0000;
                    w_wait_nxt  = '0;
                    w_state_nxt = S_MEM_WAIT;
                end else if (w_taken) begin
                    w_pc_sel = 1'b1;
                    w_flush  = 3'b111;
                end else if (w_load_use) begin
                    w_en        = 4'b0011;
                    w_flush     = 3'b010;
                    w_stall_nxt = c_STALL_INIT;
                    w_state_nxt = (LOAD_STALL > 1) ? S_LD_STALL : S_RUN;
                end
            end
            S_LD_STALL: begin
                if (w_busy) begin
                    w_en        = 4'b0000;
                    w_wait_nxt  = '0;
                    w_state_nxt = S_MEM_WAIT;
                end else if (w_taken) begin
                    w_pc_sel    = 1'b1;
                    w_flush     = 3'b111;
                    w_stall_nxt = 4'd0;
                    w_state_nxt = S_RUN;
                end else begin
                    w_en    = 4'b0011;
                    w_flush = 3'b010;
                    if (r_stall_left <= 4'd1) begin
                        w_stall_nxt = 4'd0;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_stall_nxt = r_stall_left - 4'd1;
                    end
                end
            end
            S_MEM_WAIT: begin
                if (w_busy) begin
                    w_en       = 4'b0000;
                    w_wait_nxt = w_wait_inc;
                    // Timeout abandons the access and any stall left pending
                    if (w_wait_inc == c_TIMEOUT) begin
                        w_err_set   = 1'b1;
                        w_stall_nxt = 4'd0;
                        w_state_nxt = S_RUN;
                    end
                end else if (w_taken) begin
                    w_pc_sel    = 1'b1;
                    w_flush     = 3'b111;
                    w_stall_nxt = 4'd0;
                    w_state_nxt = S_RUN;
                end else if (w_load_use) begin
                    w_en        = 4'b0011;
                    w_flush     = 3'b010;
                    w_stall_nxt = c_STALL_INIT;
                    w_state_nxt = (LOAD_STALL > 1) ? S_LD_STALL : S_RUN;
                end else begin
                    w_state_nxt = (r_stall_left != 4'd0) ? S_LD_STALL : S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs1)     w_fwd_a = 2'b10;
        else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs1)   w_fwd_a = 2'b01;
        if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs2)     w_fwd_b = 2'b10;
        else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs2)   w_fwd_b = 2'b01;
    end

    // Control outputs are forced to their reset values while rst_n is low
    assign pc_en       = rst_n & w_en[3];
    assign ifid_en     = rst_n & w_en[2];
    assign idex_en     = rst_n & w_en[1];
    assign exmem_en    = rst_n & w_en[0];
    assign ifid_flush  = ~rst_n | w_flush[2];
    assign idex_flush  = ~rst_n | w_flush[1];
    assign exmem_flush = ~rst_n | w_flush[0];
    assign pc_sel      = rst_n & w_pc_sel;
    assign fwd_a       = rst_n ? w_fwd_a : 2'b00;
    assign fwd_b       = rst_n ? w_fwd_b : 2'b00;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign mem_err     = r_mem_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RUN;
            r_stall_left <= 4'd0;
            r_wait       <= '0;
            r_mem_err    <= 1'b0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_stall_left <= w_stall_nxt;
            r_wait       <= w_wait_nxt;
            if (w_err_set)
                r_mem_err <= 1'b1;
            if (!w_en[3] && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_pc_sel && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_pipe_hazard_ctrl
// Description: Directed and random checks of pipe_hazard_ctrl against a
//              cycle-level behavioural model of the hazard rules.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int LOAD_STALL  = 2;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 6;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs2, ex_regwrite, ex_memtoreg, mem_regwrite, wb_regwrite;
    logic mem_branch, mem_jump, mem_zero, dmem_req, dmem_ack;
    logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush, pc_sel;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic mem_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: stall cycles still owed, memory-wait progress, statistics
    int   m_owed, m_waitcyc, m_sc, m_fc;
    bit   m_waiting, m_err;
    int   n_owed, n_waitcyc;
    bit   n_waiting, n_err;
    logic [7:0] e_ctrl;
    logic [3:0] e_fwd;

    pipe_hazard_ctrl #(.LOAD_STALL(LOAD_STALL), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .mem_branch(mem_branch), .mem_jump(mem_jump), .mem_zero(mem_zero),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] ctrl_obs();
        return {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush, pc_sel};
    endfunction

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_regwrite && wb_rd != 0 && wb_rd == rs)    return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owed = 0; m_waitcyc = 0; m_sc = 0; m_fc = 0; m_waiting = 0; m_err = 0;
    endtask

    task automatic model_eval();
        bit busy, taken, lu;
        logic [3:0] en;
        logic [2:0] fl;
        logic sel;
        busy  = dmem_req && !dmem_ack;
        taken = mem_jump || (mem_branch && mem_zero);
        lu    = ex_memtoreg && ex_regwrite && ex_rd != 0 &&
                (ex_rd == id_rs1 || (id_use_rs2 && ex_rd == id_rs2));
        en = 4'b1111; fl = 3'b000; sel = 1'b0;
        n_owed = m_owed; n_waiting = m_waiting; n_waitcyc = m_waitcyc; n_err = m_err;
        if (m_waiting && busy) begin
            en = 4'b0000;
            n_waitcyc = m_waitcyc + 1;
            if (n_waitcyc == MEM_TIMEOUT) begin
                n_err = 1; n_waiting = 0; n_owed = 0;
            end
        end else if (busy) begin
            en = 4'b0000; n_waiting = 1; n_waitcyc = 0;
        end else begin
            n_waiting = 0;
            if (taken) begin
                sel = 1'b1; fl = 3'b111; n_owed = 0;
            end else if (m_owed > 0 && !m_waiting) begin
                en = 4'b0011; fl = 3'b010; n_owed = m_owed - 1;
            end else if (lu) begin
                en = 4'b0011; fl = 3'b010; n_owed = LOAD_STALL - 1;
            end
        end
        e_ctrl = {en, fl, sel};
        e_fwd  = {fwd_model(ex_rs1), fwd_model(ex_rs2)};
    endtask

    task automatic model_commit();
        if (!e_ctrl[7] && m_sc < CNT_MAX) m_sc++;
        if (e_ctrl[0] && m_fc < CNT_MAX)  m_fc++;
        m_owed = n_owed; m_waiting = n_waiting; m_waitcyc = n_waitcyc; m_err = n_err;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_eval();
        check("ctrl", ctrl_obs(), e_ctrl);
        check("fwd", {fwd_a, fwd_b}, e_fwd);
        check("stall_cnt", stall_cnt, m_sc);
        check("flush_cnt", flush_cnt, m_fc);
        check("mem_err", mem_err, m_err);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
        ex_regwrite = 0; ex_memtoreg = 0; mem_rd = 0; mem_regwrite = 0; wb_rd = 0;
        wb_regwrite = 0; mem_branch = 0; mem_jump = 0; mem_zero = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    initial begin
        int n_idle, n_wait;
        bit seen;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #3;
        check("rst_ctrl", ctrl_obs(), 8'h0E);
        repeat (2) @(posedge clk);
        #1;
        check("rst_cnt", {stall_cnt, flush_cnt}, '0);
        check("rst_err", mem_err, 1'b0);
        rst_n = 1'b1;

        // Load-use on rs1: two bubble cycles
        ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 5; id_rs1 = 5;
        cycle();
        clear_inputs();
        cycle();
        cycle();
        check("ldu_stall_cnt", stall_cnt, 2);

        // Taken branch redirects and flushes; not-taken does nothing
        mem_branch = 1; mem_zero = 1;
        #1 check("br_taken_ctrl", ctrl_obs(), 8'hFF);
        cycle();
        check("br_flush_cnt", flush_cnt, 1);
        mem_zero = 0;
        #1 check("br_not_taken_ctrl", ctrl_obs(), 8'hF0);
        cycle();

        // Forwarding priority and x0 exclusion
        clear_inputs();
        ex_rs1 = 3; mem_rd = 3; wb_rd = 3; mem_regwrite = 1; wb_regwrite = 1;
        #1 check("fwd_mem", fwd_a, 2'b10);
        cycle();
        mem_regwrite = 0;
        #1 check("fwd_wb", fwd_a, 2'b01);
        cycle();
        ex_rs1 = 0; mem_rd = 0; wb_rd = 0; mem_regwrite = 1;
        #1 check("fwd_x0", fwd_a, 2'b00);
        cycle();

        // Memory wait in the middle of a load-use stall
        clear_inputs();
        ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
        cycle();
        clear_inputs();
        dmem_req = 1;
        n_idle = 0;
        for (int i = 0; i < 4; i++) begin
            #1 if (ctrl_obs()[7:4] == 4'b0000) n_idle++;
            cycle();
        end
        dmem_ack = 1;
        cycle();
        clear_inputs();
        #1 check("memwait_resume_stall", ctrl_obs(), 8'h34);
        cycle();
        #1 check("memwait_back_run", ctrl_obs(), 8'hF0);
        cycle();
        check("memwait_idle_cycles", n_idle, 4);

        // Timeout with no ack
        dmem_req = 1;
        seen = 0; n_wait = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            n_wait++;
            if (mem_err) seen = 1;
        end
        check("timeout_cycles", n_wait, 9);
        dmem_req = 0;
        repeat (3) cycle();
        check("err_sticky", mem_err, 1'b1);

        // Asynchronous reset while a load-use stall is in progress
        ex_memtoreg = 1; ex_regwrite = 1; ex_rd = 9; id_rs1 = 9;
        cycle();
        clear_inputs();
        ex_rs1 = 3; mem_rd = 3; mem_regwrite = 1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctrl", ctrl_obs(), 8'h0E);
        check("arst_fwd", {fwd_a, fwd_b}, 4'b0000);
        check("arst_cnt", {stall_cnt, flush_cnt}, '0);
        check("arst_err", mem_err, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        clear_inputs();
        cycle();
        check("arst_run_stall_cnt", stall_cnt, 0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            id_rs1       = 5'($urandom_range(0, 7));
            id_rs2       = 5'($urandom_range(0, 7));
            id_use_rs2   = 1'($urandom_range(0, 1));
            ex_rs1       = 5'($urandom_range(0, 7));
            ex_rs2       = 5'($urandom_range(0, 7));
            ex_rd        = 5'($urandom_range(0, 7));
            ex_regwrite  = ($urandom_range(0, 3) != 0);
            ex_memtoreg  = ($urandom_range(0, 2) == 0);
            mem_rd       = 5'($urandom_range(0, 7));
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_rd        = 5'($urandom_range(0, 7));
            wb_regwrite  = 1'($urandom_range(0, 1));
            mem_branch   = ($urandom_range(0, 3) == 0);
            mem_zero     = 1'($urandom_range(0, 1));
            mem_jump     = ($urandom_range(0, 11) == 0);
            dmem_req     = m_waiting ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0);
            dmem_ack     = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
